delay_line_prog: RTL and testbench

Multi-channel signed delay line with a depth that can be changed at run time, a stall enable, and a valid bit that travels with each sample. It is the parametrised successor to the fixed-depth signed shift registers in the FFT datapath. It aligns butterfly operands and twiddle paths whose skew depends on FFT size, so one instance serves every stage and transform length. All channels share one depth, one enable and one valid bit.

---
 rtl/delay_line_prog.sv | 107 ++++++++++
 tb/tb_delay_line_prog.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/delay_line_prog.sv
// Multi-channel signed delay line with run-time depth, stall enable and a valid
// tag carried alongside every sample. All channels share one depth and one tag.
module delay_line_prog #(
    parameter int WIDTH         = 16,
    parameter int NUM_CH        = 4,
    parameter int MAX_DEPTH     = 64,
    parameter int DEFAULT_DEPTH = MAX_DEPTH,
    parameter int DW            = $clog2(MAX_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DW-1:0]           cfg_depth,
    input  logic                    cfg_load,
    input  logic                    in_en,
    input  logic                    in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic                    out_valid,
    output logic [NUM_CH*WIDTH-1:0] out_data,
    output logic                    primed,
    output logic [DW-1:0]           depth
);

    localparam int DATA_W = NUM_CH * WIDTH;
    localparam int PW     = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

    logic [DATA_W-1:0]    mem [MAX_DEPTH];
    logic [MAX_DEPTH-1:0] vbits;
    logic [DW-1:0]        ptr;
    logic [DW-1:0]        fill;

    logic [DW-1:0]        last_ptr;
    logic [DW-1:0]        rd_ptr;
    logic [DW-1:0]        fill_next;
    logic [DW-1:0]        depth_clamped;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_valid;
    logic                 accept;

    assign accept = rst_n && !cfg_load && in_en;

    // The slot after the write pointer was written D-1 accepted samples ago,
    // so reading it into the output register yields a total latency of D.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        last_ptr      = depth - DW'(1);
        rd_ptr        = (ptr == last_ptr) ? '0 : ptr + DW'(1);
        fill_next     = (fill == depth) ? fill : fill + DW'(1);
        rd_data       = mem[rd_ptr[PW-1:0]];
        rd_valid      = vbits[rd_ptr[PW-1:0]];
        depth_clamped = cfg_depth;

        // With D=1 the read slot is the one being written: forward the input.
        if (rd_ptr == ptr) begin
            rd_data  = in_data;
            rd_valid = in_valid;
        end

        if (cfg_depth == '0) begin
            depth_clamped = DW'(1);
        end else if (cfg_depth > DW'(MAX_DEPTH)) begin
            depth_clamped = DW'(MAX_DEPTH);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            depth     <= DW'(DEFAULT_DEPTH);
            ptr       <= '0;
            fill      <= '0;
            vbits     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else if (cfg_load) begin
            depth     <= depth_clamped;
            ptr       <= '0;
            fill      <= '0;
            vbits     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            primed    <= 1'b0;
        end else if (in_en) begin
            ptr                <= rd_ptr;
            fill               <= fill_next;
            vbits[ptr[PW-1:0]] <= in_valid;
            // Output stays zero until D post-flush samples exist, hiding stale slots.
            if (fill_next == depth) begin
                out_valid <= rd_valid;
                out_data  <= rd_data;
                primed    <= 1'b1;
            end else begin
                out_valid <= 1'b0;
                out_data  <= '0;
                primed    <= 1'b0;
            end
        end
    end

    // NOTE: the sample store is deliberately not reset; the fill gate keeps stale words off the output.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[ptr[PW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_delay_line_prog.sv
// Self-checking bench for delay_line_prog: queue-based reference model compared
// every cycle, plus hand-computed checks for each scenario of interest.
module tb_delay_line_prog;

    localparam int WIDTH     = 16;
    localparam int NUM_CH    = 2;
    localparam int MAX_DEPTH = 8;
    localparam int DW        = $clog2(MAX_DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [DW-1:0]           cfg_depth;
    logic                    cfg_load;
    logic                    in_en;
    logic                    in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic                    out_valid;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic                    primed;
    logic [DW-1:0]           depth;

    delay_line_prog #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .MAX_DEPTH(MAX_DEPTH), .DEFAULT_DEPTH(MAX_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_depth(cfg_depth), .cfg_load(cfg_load),
        .in_en(in_en), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .primed(primed), .depth(depth)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the list of samples accepted since the last flush.
    // Once at least D exist, the output is the D-th most recent one.
    logic [32:0] hist[$];
    int          m_depth = MAX_DEPTH;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_depth = MAX_DEPTH;
            hist.delete();
        end else if (cfg_load) begin
            m_depth = (cfg_depth == 0) ? 1 : (int'(cfg_depth) > MAX_DEPTH) ? MAX_DEPTH : int'(cfg_depth);
            hist.delete();
        end else if (in_en) begin
            hist.push_back({in_valid, in_data});
        end
    end

    logic [32:0] exp_s;
    bit          exp_p;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_p = (hist.size() >= m_depth);
            exp_s = exp_p ? hist[hist.size() - m_depth] : 33'd0;
            check("model_valid",  {63'd0, out_valid}, {63'd0, exp_s[32]});
            check("model_data",   {32'd0, out_data},  {32'd0, exp_s[31:0]});
            check("model_primed", {63'd0, primed},    {63'd0, exp_p});
            check("model_depth",  {60'd0, depth},     64'(m_depth));
        end
    end

    function automatic logic [31:0] pk(input int c1, input int c0);
        return {16'(c1), 16'(c0)};
    endfunction

    task automatic step(input logic r, input logic ld, input logic [DW-1:0] cd,
                        input logic en, input logic v, input logic [31:0] d);
        rst_n     = r;
        cfg_load  = ld;
        cfg_depth = cd;
        in_en     = en;
        in_valid  = v;
        in_data   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int d);
        step(1'b1, 1'b1, DW'(d), 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_load = 1'b0; cfg_depth = '0;
        in_en = 1'b0; in_valid = 1'b0; in_data = '0;

        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 32'd0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 32'd0);
        check("reset_valid",  {63'd0, out_valid}, 64'd0);
        check("reset_data",   {32'd0, out_data},  64'd0);
        check("reset_primed", {63'd0, primed},    64'd0);
        check("reset_depth",  {60'd0, depth},     64'd8);

        // Post-reset fill at D=8: ch0=-k, ch1=k.
        for (int k = 1; k <= 9; k++) begin
            step(1'b1, 1'b0, '0, 1'b1, 1'b1, pk(k, -k));
            if (k == 7) begin
                check("fill7_valid",  {63'd0, out_valid}, 64'd0);
                check("fill7_primed", {63'd0, primed},    64'd0);
            end
            if (k == 8) begin
                check("fill8_valid",  {63'd0, out_valid}, 64'd1);
                check("fill8_data",   {32'd0, out_data},  64'h0001_FFFF);
                check("fill8_primed", {63'd0, primed},    64'd1);
            end
            if (k == 9) check("fill9_data", {32'd0, out_data}, 64'h0002_FFFE);
        end

        // Depth 1 and clamping.
        load(0);
        check("clamp0_depth", {60'd0, depth}, 64'd1);
        step(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h0000_8000);
        check("d1_valid", {63'd0, out_valid}, 64'd1);
        check("d1_data",  {32'd0, out_data},  64'h0000_8000);
        load(15);
        check("clamp15_depth", {60'd0, depth}, 64'd8);

        // Stall at D=3: after sample 4, five idle cycles, then resume.
        load(3);
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 1'b0, '0, 1'b1, 1'b1, pk(k, k));
            if (k >= 3) check("stall_seq", {32'd0, out_data}, {32'd0, pk(k - 2, k - 2)});
            if (k == 4) begin
                for (int s = 0; s < 5; s++) begin
                    step(1'b1, 1'b0, '0, 1'b0, 1'b0, pk(99, 99));
                    check("stall_hold", {32'd0, out_data}, {32'd0, pk(2, 2)});
                end
            end
        end

        // Live reconfiguration from D=8 to D=3 with in_en high.
        load(8);
        for (int k = 1; k <= 12; k++) step(1'b1, 1'b0, '0, 1'b1, 1'b1, pk(k, 50 + k));
        step(1'b1, 1'b1, DW'(3), 1'b1, 1'b1, pk(77, 77));
        check("reload_valid",  {63'd0, out_valid}, 64'd0);
        check("reload_data",   {32'd0, out_data},  64'd0);
        check("reload_primed", {63'd0, primed},    64'd0);
        check("reload_depth",  {60'd0, depth},     64'd3);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, '0, 1'b1, 1'b1, pk(100 + k, 100 + k));
            if (k < 2) check("reload_early", {63'd0, out_valid}, 64'd0);
        end
        check("reload_first", {31'd0, out_valid, out_data}, {31'd0, 1'b1, pk(100, 100)});

        // Valid gaps at D=4.
        begin
            logic [7:0] vpat;
            vpat = 8'b1110_1101;  // bit i is the tag of sample i
            load(4);
            for (int i = 0; i < 8; i++) begin
                step(1'b1, 1'b0, '0, 1'b1, vpat[i], pk(i, 16 + i));
                if (i >= 3) begin
                    check("gap_valid", {63'd0, out_valid}, {63'd0, vpat[i - 3]});
                    check("gap_data",  {32'd0, out_data},  {32'd0, pk(i - 3, 13 + i)});
                end
            end
        end

        // Reset wins over simultaneous load and enable.
        step(1'b0, 1'b1, DW'(2), 1'b1, 1'b1, pk(5, 5));
        check("rstpri_valid",  {63'd0, out_valid}, 64'd0);
        check("rstpri_data",   {32'd0, out_data},  64'd0);
        check("rstpri_primed", {63'd0, primed},    64'd0);
        check("rstpri_depth",  {60'd0, depth},     64'd8);

        // Randomized traffic, checked by the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = $urandom_range(0, 199);
            step((r != 0), (r >= 1 && r <= 4), DW'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) != 0), 1'($urandom), 32'($urandom));
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
